// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants for the multdiv controller: FSM state codes, op encodings and
// the default watchdog length.
package multdiv_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 40;

endpackage

// File: rtl/multdiv_watchdog.sv
// WAIT-state cycle counter; o_expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module multdiv_watchdog
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed WAIT cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1.
  assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and an iterative mult/div unit, with writeback handshake.
// Optional WAIT-state watchdog compiled in with MULTDIV_CTRL_TIMEOUT_EN.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned RD_W           = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic            req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic            req_ready,
  input  logic            flush,
  output logic [31:0]     md_operandA,
  output logic [31:0]     md_operandB,
  output logic            md_ctrl_MULT,
  output logic            md_ctrl_DIV,
  input  logic [31:0]     md_result,
  input  logic            md_exception,
  input  logic            md_resultRDY,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_exception,
  output logic            wb_timeout,
  output logic            busy,
  output logic [1:0]      o_dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // valid never depends on ready, and flush suppresses any request transfer in its cycle.
  logic [1:0]      r_state;
  logic            r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [RD_W-1:0] r_rd;
  logic [31:0]     r_wb_data;
  logic [RD_W-1:0] r_wb_rd;
  logic            r_wb_exc;
  logic            w_accept;

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = req_valid && req_ready && !flush;
  assign md_operandA  = r_a;
  assign md_operandB  = r_b;
  assign md_ctrl_MULT = (r_state == ST_START) && (r_op == OP_MULT);
  assign md_ctrl_DIV  = (r_state == ST_START) && (r_op == OP_DIV);
  assign wb_valid     = (r_state == ST_DONE);
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_exception = r_wb_exc;
  assign o_dbg_state  = r_state;

`ifdef MULTDIV_CTRL_TIMEOUT_EN
  logic r_wb_timeout;
  logic w_expired;

  multdiv_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (r_state == ST_START),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  assign wb_timeout = r_wb_timeout;
`else
  assign wb_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MULT;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_exc  <= 1'b0;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
      r_wb_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_rd    <= req_rd;
            r_state <= ST_START;
          end
        end
        // A leftover md_resultRDY is deliberately not looked at here.
        ST_START: r_state <= flush ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (md_resultRDY) begin
            r_wb_data <= md_result;
            r_wb_exc  <= md_exception;
            r_wb_rd   <= r_rd;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
            r_wb_timeout <= 1'b0;
`endif
            r_state   <= ST_DONE;
          end
`ifdef MULTDIV_CTRL_TIMEOUT_EN
          else if (w_expired) begin
            r_wb_data    <= '0;
            r_wb_exc     <= 1'b1;
            r_wb_rd      <= r_rd;
            r_wb_timeout <= 1'b1;
            r_state      <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          if (flush || wb_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: hand-computed results go into an expected queue that a
// writeback monitor drains; inline checks cover the control pulses, stalls, flush and reset.
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

`ifdef MULTDIV_CTRL_TIMEOUT_EN
  localparam int TO      = 8;
  localparam int MUL_LAT = 6;
  localparam int FL_CYC  = 5;
`else
  localparam int TO      = 40;
  localparam int MUL_LAT = 33;
  localparam int FL_CYC  = 10;
`endif
  localparam int EW = 39;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;
  logic        wb_timeout;
  logic        busy;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_mult  = 0;
  int n_div   = 0;
  logic [EW-1:0] exp_q[$];

  multdiv_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .RD_W           (5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .req_ready    (req_ready),
    .flush        (flush),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_exception (wb_exception),
    .wb_timeout   (wb_timeout),
    .busy         (busy),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: every accepted writeback must match the head of exp_q
  always @(negedge clock) begin
    if (md_ctrl_MULT) n_mult++;
    if (md_ctrl_DIV)  n_div++;
    if (md_ctrl_MULT && md_ctrl_DIV) chk("ctrl_mutex", 1, 0);
    if (reset_n && wb_valid && wb_ready) begin
      if (exp_q.size() > 0) chk("wb", {wb_timeout, wb_exception, wb_rd, wb_data}, exp_q.pop_front());
      else chk("wb_unexpected", 1, 0);
    end
  end

  // driver: one operation, RDY in WAIT cycle k, optional wb_ready=0 hold of 'hold' cycles
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input logic [31:0] res,
                        input logic exc, input int hold);
    int m0;
    int d0;
    m0 = n_mult;
    d0 = n_div;
    chk("pre_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    exp_q.push_back({1'b0, exc, rd, res});
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    @(negedge clock);
    chk("start_mult", md_ctrl_MULT, op == OP_MULT);
    chk("start_div", md_ctrl_DIV, op == OP_DIV);
    chk("start_busy", busy, 1);
    tick();
    for (int i = 1; i < k; i++) tick();
    @(negedge clock);
    chk("wait_opA", md_operandA, a);
    chk("wait_opB", md_operandB, b);
    chk("wait_valid", wb_valid, 0);
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    if (hold > 0) wb_ready = 1'b0;
    tick();
    md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("bp_valid", wb_valid, 1);
      chk("bp_data", wb_data, res);
      chk("bp_req_ready", req_ready, 0);
      req_valid = 1'b1;
      tick();
    end
    wb_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    chk("end_busy", busy, 0);
    chk("end_valid", wb_valid, 0);
    chk("mult_pulses", n_mult - m0, (op == OP_MULT) ? 1 : 0);
    chk("div_pulses", n_div - d0, (op == OP_DIV) ? 1 : 0);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = OP_MULT; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0; wb_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_state", o_dbg_state, ST_IDLE);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_opA", md_operandA, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();

    run_op(OP_MULT, 32'd7, 32'd6, 5'd3, MUL_LAT, 32'd42, 1'b0, 0);
    run_op(OP_DIV, 32'd100, 32'd0, 5'd7, 5, 32'd0, 1'b1, 0);
    run_op(OP_MULT, 32'd9, 32'd9, 5'd17, 4, 32'd81, 1'b0, 5);
    run_op(OP_DIV, 32'd1000, 32'd7, 5'd30, 2, 32'd142, 1'b0, 0);
    run_op(OP_MULT, 32'h0000_FFFF, 32'h0001_0001, 5'd31, 1, 32'hFFFF_FFFF, 1'b0, 0);

    // flush mid-WAIT (together with a RDY), then a stale RDY in the next START
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd5; req_rd = 5'd3;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i < FL_CYC; i++) tick();
    flush = 1'b1; md_resultRDY = 1'b1; md_result = 32'd15;
    tick();
    flush = 1'b0; md_resultRDY = 1'b0;
    @(negedge clock);
    chk("flush_state", o_dbg_state, ST_IDLE);
    chk("flush_valid", wb_valid, 0);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd50; req_b = 32'd7; req_rd = 5'd9;
    exp_q.push_back({1'b0, 1'b0, 5'd9, 32'd7});
    tick();
    req_valid = 1'b0; md_resultRDY = 1'b1; md_result = 32'd15;
    @(negedge clock);
    chk("stale_div", md_ctrl_DIV, 1);
    tick();
    md_resultRDY = 1'b0;
    @(negedge clock);
    chk("stale_state", o_dbg_state, ST_WAIT);
    chk("stale_valid", wb_valid, 0);
    tick(); tick();
    md_resultRDY = 1'b1; md_result = 32'd7;
    tick();
    md_resultRDY = 1'b0;
    tick();
    @(negedge clock);
    chk("flush_end_busy", busy, 0);
    tick();

`ifdef MULTDIV_CTRL_TIMEOUT_EN
    // watchdog expiry with no RDY, then RDY landing exactly on the expiry cycle
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd1; req_b = 32'd1; req_rd = 5'd4;
    exp_q.push_back({1'b1, 1'b1, 5'd4, 32'd0});
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i < TO - 1; i++) tick();
    @(negedge clock);
    chk("wd_pre_valid", wb_valid, 0);
    chk("wd_pre_busy", busy, 1);
    tick();
    @(negedge clock);
    chk("wd_last_valid", wb_valid, 0);
    tick();
    @(negedge clock);
    chk("wd_valid", wb_valid, 1);
    chk("wd_timeout", wb_timeout, 1);
    tick();
    run_op(OP_MULT, 32'd2, 32'd3, 5'd5, TO, 32'd6, 1'b0, 0);
`endif

    // reset asserted in WAIT
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd11; req_b = 32'd13; req_rd = 5'd21;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_state", o_dbg_state, ST_IDLE);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    chk("mrst_wb", {wb_valid, wb_exception, wb_timeout}, 0);
    chk("mrst_wb_data", wb_data, 0);
    chk("mrst_wb_rd", wb_rd, 0);
    chk("mrst_ops", {md_operandA, md_operandB}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    md_resultRDY = 1'b1; md_result = 32'd143;
    tick();
    md_resultRDY = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    chk("post_rst_busy", busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
